// File: rtl/mesi_isc_mem_ctrl.sv
// Main-memory controller for the MESI ISC: arbitrates CPU_COUNT main-bus requesters
// onto one shared word memory, one access at a time, with programmable read latency.
module mesi_isc_mem_ctrl #(
  parameter int CPU_COUNT      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH      = 16,
  parameter int RD_LATENCY     = 2,
  parameter int PRIO_MODE      = 0,
  parameter int MBUS_CMD_WIDTH = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [CPU_COUNT*MBUS_CMD_WIDTH-1:0] mbus_cmd,
  input  logic [CPU_COUNT*ADDR_WIDTH-1:0]     mbus_addr,
  input  logic [CPU_COUNT*DATA_WIDTH-1:0]     mbus_data_wr,
  output logic [CPU_COUNT-1:0]                mbus_ack,
  output logic [DATA_WIDTH-1:0]               mbus_data_rd,
  output logic                                mbus_err,
  output logic                                busy,
  output logic [CPU_COUNT*16-1:0]             stat_rd,
  output logic [CPU_COUNT*16-1:0]             stat_wr
);

  // state | meaning
  // IDLE  | scanning requesters for a WR/RD command
  // WAIT  | access granted and latched, latency counter running
  // RESP  | one-cycle ack to the granted CPU, memory write/stat update done on entry

  localparam int PW = (CPU_COUNT > 1) ? $clog2(CPU_COUNT) : 1;
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = MBUS_CMD_WIDTH;
  localparam logic [CW-1:0] CMD_WR = CW'(1);
  localparam logic [CW-1:0] CMD_RD = CW'(2);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         scan_start;
  logic [PW-1:0]         hit_idx;
  logic                  hit;
  logic [CW-1:0]         hit_cmd;
  int                    scan_j;
  logic [CW-1:0]         scan_cmd;

  logic [PW-1:0]         lat_cpu;
  logic [CW-1:0]         lat_cmd;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [3:0]            cnt;
  logic                  in_range;
  logic [IW-1:0]         mem_idx;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [15:0]           rd_cnt [CPU_COUNT];
  logic [15:0]           wr_cnt [CPU_COUNT];

  // Scan wraps modulo CPU_COUNT from the start point; first valid command wins.
  always_comb begin
    scan_start = (PRIO_MODE != 0) ? '0 : rr_ptr;
    hit        = 1'b0;
    hit_idx    = '0;
    scan_j     = 0;
    scan_cmd   = '0;
    for (int i = 0; i < CPU_COUNT; i++) begin
      scan_j   = (int'(scan_start) + i) % CPU_COUNT;
      scan_cmd = mbus_cmd[scan_j*CW +: CW];
      if (!hit && (scan_cmd == CMD_WR || scan_cmd == CMD_RD)) begin
        hit     = 1'b1;
        hit_idx = PW'(scan_j);
      end
    end
  end

  assign hit_cmd  = mbus_cmd[int'(hit_idx)*CW +: CW];
  assign in_range = (lat_addr < ADDR_WIDTH'(MEM_DEPTH));
  assign mem_idx  = lat_addr[IW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (hit) state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mbus_ack     = '0;
    mbus_err     = 1'b0;
    mbus_data_rd = '0;
    busy         = (state != ST_IDLE);
    if (state == ST_RESP) begin
      mbus_ack[lat_cpu] = 1'b1;
      mbus_err          = !in_range;
      if (lat_cmd == CMD_RD && in_range) mbus_data_rd = mem[mem_idx];
    end
  end

  // Request latch, latency counter, memory write, stats and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cpu   <= '0;
      lat_cmd   <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      rr_ptr    <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      for (int i = 0; i < CPU_COUNT; i++) begin
        rd_cnt[i] <= '0;
        wr_cnt[i] <= '0;
      end
    end else begin
      if (state == ST_IDLE && hit) begin
        lat_cpu   <= hit_idx;
        lat_cmd   <= hit_cmd;
        lat_addr  <= mbus_addr[int'(hit_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        lat_wdata <= mbus_data_wr[int'(hit_idx)*DATA_WIDTH +: DATA_WIDTH];
        cnt       <= (hit_cmd == CMD_RD) ? 4'(RD_LATENCY - 1) : 4'd0;
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == ST_WAIT && cnt == 4'd0) begin
        if (lat_cmd == CMD_WR && in_range) mem[mem_idx] <= lat_wdata;
        if (lat_cmd == CMD_RD) begin
          if (rd_cnt[lat_cpu] != 16'hFFFF) rd_cnt[lat_cpu] <= rd_cnt[lat_cpu] + 16'd1;
        end else begin
          if (wr_cnt[lat_cpu] != 16'hFFFF) wr_cnt[lat_cpu] <= wr_cnt[lat_cpu] + 16'd1;
        end
        if (PRIO_MODE == 0)
          rr_ptr <= (lat_cpu == PW'(CPU_COUNT - 1)) ? '0 : lat_cpu + PW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < CPU_COUNT; gi++) begin : g_stat
    assign stat_rd[gi*16 +: 16] = rd_cnt[gi];
    assign stat_wr[gi*16 +: 16] = wr_cnt[gi];
  end

endmodule
